instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Instruction fetch stage of the 16-bit RISC core: owns the program counter, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register whose opcode field feeds the control unit. It sits directly upstream of decode and control, absorbs decode stalls with a one-entry skid buffer, and redirects on branch/jump resolution.

## Interface
- RESET_PC, 16'h0000: first fetch address after reset; bit 0 must be 0.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  16  byte address of the fetch; stable while imem_req=1.
- imem_ack  in  1  rdata valid this cycle; completes the request.
- imem_rdata  in  16  fetched instruction.
- stall  in  1  decode cannot accept a new instruction this cycle.
- redirect  in  1  branch taken or jump; flush and refetch.
- redirect_pc  in  16  new fetch address; bit 0 ignored (treated as 0).
- id_valid  out  1  IF/ID register holds a live instruction.
- id_instr  out  16  IF/ID instruction.
- id_pc_plus2  out  16  fetch address + 2 of id_instr (branch base).
- id_opcode  out  4  id_instr[15:12], to control unit.

## Operation
- States: START, FETCH, HOLD, DRAIN.
- START: reset state; imem_req=0; unconditionally goes to FETCH next cycle (at which point a pending redirect is honoured).
- FETCH: imem_req=1, imem_addr=req_addr.
  - Ack, no redirect, ID free (id_valid=0 or stall=0): load id_instr=imem_rdata, id_pc_plus2=req_addr+2, id_valid=1; req_addr+=2; stay FETCH.
  - Ack, no redirect, ID busy (id_valid=1 and stall=1): capture into skid (instr, addr+2); req_addr+=2; go HOLD.
  - No ack: hold req_addr; if ID consumed (id_valid and !stall), id_valid<=0.
- HOLD: imem_req=0. When stall=0: skid moves into ID; go FETCH.
- Redirect (highest priority, any state): id_valid<=0, skid discarded, req_addr<=redirect_pc&~1.
  - FETCH with ack same cycle: data discarded; FETCH at new address.
  - FETCH without ack: go DRAIN; old request stays asserted at old address.
  - HOLD: go FETCH.
  - DRAIN: latest redirect_pc wins; stay DRAIN.
- DRAIN: imem_req=1 at old address; on ack discard data, go FETCH at req_addr.
- Address arithmetic: 16-bit, modulo 2^16; 16'hFFFE+2 = 16'h0000.
- id_instr/id_pc_plus2 keep their value on flush; consumers qualify with id_valid (opcode 0000 is LW, not a NOP).
- id_opcode is combinational from id_instr.

## Timing
- Reset (async assert): state=START, req_addr=RESET_PC, id_valid=0, id_instr=0, id_pc_plus2=0, skid empty, imem_req=0.
- First imem_req: cycle after rst_n deassert is sampled.
- Zero-wait memory: one instruction per cycle; ack in cycle N -> id_valid in N+1.
- Redirect in cycle N (FETCH, ack or no request outstanding): imem_addr=redirect_pc in N+1; earliest new id_valid N+2.
- Stall held: at most one instruction buffered in skid; no further requests until drained.
- imem_addr/imem_req never change while a request is outstanding without ack.

## Structure
- Shared package risc16_pkg: OPCODE_W=4, INSTR_W=16, PC_STEP=2, fetch state enum (START/FETCH/HOLD/DRAIN).
- One sub-module: fetch_skid_buf (one-entry buffer, instr+pc_plus2, load/unload/flush).
- PC/FSM logic and IF/ID register live in instr_fetch_stage.

## Test plan
- Reset then zero-wait memory returning addr as data -> id_instr sequence 0000,0002,0004 on consecutive cycles, id_pc_plus2 = addr+2, first id_valid 2 cycles after reset release.
- stall=1 for 3 cycles while ack arrives -> skid holds instr 0x0006, imem_req=0 during HOLD, no instruction lost or duplicated after release.
- redirect to 0x0040 with 3-cycle memory latency mid-request -> old request held to ack, data discarded, next imem_addr=0x0040, id_valid=0 until it returns.
- redirect to 0x0081 and ack same cycle -> fetched data dropped, imem_addr=0x0080 next cycle.
- RESET_PC=16'hFFFE -> fetches FFFE then 0000; id_pc_plus2 = 0000 then 0002.
- rst_n asserted mid-HOLD -> all outputs at reset values immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared types and constants for the 16-bit RISC core front end.
package risc16_pkg;

  localparam int OPCODE_W = 4;
  localparam int INSTR_W  = 16;
  localparam int PC_W     = 16;
  localparam logic [PC_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Wraps modulo 2^16, so 16'hFFFE steps to 16'h0000.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its pc+2 while decode stalls.
module fetch_skid_buf
  import risc16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               unload,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_plus2_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus2
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_plus2_q, pc_plus2_d;

  // Flush beats load, load beats unload.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_plus2_d = pc_plus2_in;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus2_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc_plus2 = pc_plus2_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack, IF/ID register, skid for decode stalls.
// Handshake: imem_req/imem_addr hold steady until imem_ack; a cycle with req&ack transfers rdata.
module instr_fetch_stage
  import risc16_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                id_valid,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [PC_W-1:0]     id_pc_plus2,
  output logic [OPCODE_W-1:0] id_opcode,
  output fetch_state_e        dbg_state
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    req_addr_q, req_addr_d;
  logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc2_q, id_pc2_d;

  logic               skid_load, skid_unload, skid_flush, skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc2;

  logic            id_busy;
  logic [PC_W-1:0] redirect_addr;

  assign id_busy       = id_valid_q && stall;
  assign redirect_addr = {redirect_pc[PC_W-1:1], 1'b0};

  fetch_skid_buf u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (skid_load),
    .unload      (skid_unload),
    .flush       (skid_flush),
    .instr_in    (imem_rdata),
    .pc_plus2_in (next_pc(req_addr_q)),
    .valid       (skid_valid),
    .instr       (skid_instr),
    .pc_plus2    (skid_pc2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= START;
      req_addr_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc2_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      drain_addr_q <= drain_addr_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc2_q     <= id_pc2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        if (redirect)               state_d = imem_ack ? FETCH : DRAIN;
        else if (imem_ack && id_busy) state_d = HOLD;
      end
      HOLD:  if (redirect || !stall) state_d = FETCH;
      DRAIN: if (imem_ack) state_d = FETCH;
      default: state_d = START;
    endcase
  end

  // Redirect overrides everything; an unacked request keeps its old address in drain_addr.
  always_comb begin
    req_addr_d   = req_addr_q;
    drain_addr_d = drain_addr_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc2_d     = id_pc2_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_flush   = 1'b0;
    if (redirect) begin
      id_valid_d = 1'b0;
      skid_flush = 1'b1;
      req_addr_d = redirect_addr;
      if (state_q == FETCH && !imem_ack) drain_addr_d = req_addr_q;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            req_addr_d = next_pc(req_addr_q);
            if (id_busy) begin
              skid_load = 1'b1;
            end else begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rdata;
              id_pc2_d   = next_pc(req_addr_q);
            end
          end else if (id_valid_q && !stall) begin
            id_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_valid_d  = skid_valid;
            id_instr_d  = skid_instr;
            id_pc2_d    = skid_pc2;
            skid_unload = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr   = (state_q == DRAIN) ? drain_addr_q : req_addr_q;
    id_valid    = id_valid_q;
    id_instr    = id_instr_q;
    id_pc_plus2 = id_pc2_q;
    id_opcode   = id_instr_q[INSTR_W-1 -: OPCODE_W];
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: memory returns its address as data.
module tb_instr_fetch_stage;
  import risc16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic        imem_req, imem_ack, id_valid;
  logic [15:0] imem_addr, imem_rdata, id_instr, id_pc_plus2;
  logic [3:0]  id_opcode;
  fetch_state_e dbg_state;

  logic        imem_req2, imem_ack2, id_valid2;
  logic [15:0] imem_addr2, imem_rdata2, id_instr2, id_pc_plus22;
  logic [3:0]  id_opcode2;
  fetch_state_e dbg_state2;

  int unsigned mem_lat = 0;
  int unsigned wait_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc_plus2(id_pc_plus2), .id_opcode(id_opcode),
    .dbg_state(dbg_state)
  );

  instr_fetch_stage #(.RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid2),
    .id_instr(id_instr2), .id_pc_plus2(id_pc_plus22), .id_opcode(id_opcode2),
    .dbg_state(dbg_state2)
  );

  // Memory model: ack after mem_lat waiting cycles, data = address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wait_cnt <= 0;
    else if (imem_req && !imem_ack)  wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end
  assign imem_ack    = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata  = imem_addr;
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = imem_addr2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_instr", 32'(id_instr), 32'h0);
    check("rst_pc2", 32'(id_pc_plus2), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(START));

    // Zero-wait streaming
    rst_n = 1'b1;
    step();
    check("e1_req", 32'(imem_req), 32'd1);
    check("e1_addr", 32'(imem_addr), 32'h0000);
    check("e1_valid", 32'(id_valid), 32'd0);
    check("wrap_e1_addr", 32'(imem_addr2), 32'hFFFE);
    step();
    check("e2_valid", 32'(id_valid), 32'd1);
    check("e2_instr", 32'(id_instr), 32'h0000);
    check("e2_pc2", 32'(id_pc_plus2), 32'h0002);
    check("e2_addr", 32'(imem_addr), 32'h0002);
    check("wrap_e2_instr", 32'(id_instr2), 32'hFFFE);
    check("wrap_e2_pc2", 32'(id_pc_plus22), 32'h0000);
    check("wrap_e2_addr", 32'(imem_addr2), 32'h0000);
    step();
    check("e3_instr", 32'(id_instr), 32'h0002);
    check("e3_pc2", 32'(id_pc_plus2), 32'h0004);
    check("wrap_e3_instr", 32'(id_instr2), 32'h0000);
    check("wrap_e3_pc2", 32'(id_pc_plus22), 32'h0002);
    step();
    check("e4_instr", 32'(id_instr), 32'h0004);
    check("e4_pc2", 32'(id_pc_plus2), 32'h0006);

    // Stall for 3 cycles: 0x0006 goes to skid
    stall = 1'b1;
    step();
    check("hold1_state", 32'(dbg_state), 32'(HOLD));
    check("hold1_req", 32'(imem_req), 32'd0);
    check("hold1_instr", 32'(id_instr), 32'h0004);
    step();
    check("hold2_req", 32'(imem_req), 32'd0);
    check("hold2_instr", 32'(id_instr), 32'h0004);
    step();
    check("hold3_req", 32'(imem_req), 32'd0);
    check("hold3_valid", 32'(id_valid), 32'd1);
    stall = 1'b0;
    step();
    check("unskid_instr", 32'(id_instr), 32'h0006);
    check("unskid_pc2", 32'(id_pc_plus2), 32'h0008);
    check("unskid_req", 32'(imem_req), 32'd1);
    check("unskid_addr", 32'(imem_addr), 32'h0008);
    step();
    check("after_instr", 32'(id_instr), 32'h0008);
    check("after_valid", 32'(id_valid), 32'd1);

    // Redirect to 0x0040 mid-request with 3-cycle latency
    mem_lat = 3;
    step();
    check("lat_consumed", 32'(id_valid), 32'd0);
    check("lat_addr", 32'(imem_addr), 32'h000A);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check("drain_state", 32'(dbg_state), 32'(DRAIN));
    check("drain_req", 32'(imem_req), 32'd1);
    check("drain_addr", 32'(imem_addr), 32'h000A);
    step();
    check("drain2_addr", 32'(imem_addr), 32'h000A);
    step();
    check("refetch_addr", 32'(imem_addr), 32'h0040);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_valid", 32'(id_valid), 32'd0);
    end
    step();
    check("redir_valid", 32'(id_valid), 32'd1);
    check("redir_instr", 32'(id_instr), 32'h0040);
    check("redir_pc2", 32'(id_pc_plus2), 32'h0042);

    // Redirect to 0x0081 with ack the same cycle
    mem_lat = 0;
    redirect = 1'b1;
    redirect_pc = 16'h0081;
    step();
    redirect = 1'b0;
    check("ack_redir_addr", 32'(imem_addr), 32'h0080);
    check("ack_redir_valid", 32'(id_valid), 32'd0);
    check("ack_redir_keep", 32'(id_instr), 32'h0040);
    step();
    check("ack_redir_instr", 32'(id_instr), 32'h0080);
    check("ack_redir_pc2", 32'(id_pc_plus2), 32'h0082);
    check("ack_redir_opc", 32'(id_opcode), 32'h0);

    // Async reset in the middle of HOLD
    stall = 1'b1;
    step();
    check("pre_rst_state", 32'(dbg_state), 32'(HOLD));
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(id_valid), 32'd0);
    check("arst_instr", 32'(id_instr), 32'h0);
    check("arst_pc2", 32'(id_pc_plus2), 32'h0);
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(START));
    stall = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rerun_addr", 32'(imem_addr), 32'h0000);
    check("rerun_req", 32'(imem_req), 32'd1);
    step();
    check("rerun_valid", 32'(id_valid), 32'd1);
    check("rerun_instr", 32'(id_instr), 32'h0000);
    check("rerun_pc2", 32'(id_pc_plus2), 32'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
